// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory port, the redirect input and
// the decode-side output handshake of the fetch queue.
//
// Handshake semantics (both channels):
//   imem_req/imem_addr: a request is issued in every cycle imem_req is high.
//     The memory always accepts it. Responses come back in request order,
//     at least one cycle later, as imem_rvalid/imem_rdata.
//   out_valid/out_ready: the head entry is transferred in a cycle where both
//     are high. While out_valid is high and out_ready is low, out_instr and
//     out_pc_plus_step hold steady. out_valid never depends on out_ready.
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc_plus_step;

  // Fetch queue side.
  modport master (
    input  redirect, redirect_pc, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc_plus_step
  );

  // Environment side: memory, branch resolution and decode.
  modport slave (
    output redirect, redirect_pc, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc_plus_step
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch front end. Keeps up to DEPTH
// memory requests in flight, buffers responses in an in-order queue and
// hands them to decode. A redirect flushes the queue and discards the
// responses still owed by the memory for requests issued before it.
// Optional feature macro: FETCH_PERF_EN adds perf_stall_cycles, a saturating
// count of non-reset cycles with no valid instruction at the output.
module fetch_queue #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] INIT_ADDR = '0,
  parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = PTR_W + 2;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [SUM_W-1:0]  credit_used;
  logic              issue;
  logic              push;
  logic              drop;
  logic              pop;

  // Every queue slot is reserved at issue time, so a response always has room.
  assign credit_used = SUM_W'(count) + SUM_W'(outstanding);
  assign issue       = !reset && !bus.redirect && (credit_used < SUM_W'(DEPTH));

  // A response is either owed to a flushed request (drop) or kept (push).
  // Anything arriving in a redirect cycle belongs to the old path.
  assign push = bus.imem_rvalid && (drop_cnt == '0) && !bus.redirect;
  assign drop = bus.imem_rvalid && (drop_cnt != '0) && !bus.redirect;

  assign bus.out_valid        = !reset && (count != '0) && !bus.redirect;
  assign pop                  = bus.out_valid && bus.out_ready;
  assign bus.imem_req         = issue;
  assign bus.imem_addr        = fetch_pc;
  assign bus.out_instr        = q_instr[head];
  assign bus.out_pc_plus_step = q_pc[head] + PC_STEP;

  // Control state: PCs, pointers, occupancy, in-flight and drop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= INIT_ADDR;
      resp_pc     <= INIT_ADDR;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(bus.imem_rvalid);
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
        resp_pc  <= bus.redirect_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        drop_cnt <= outstanding - CNT_W'(bus.imem_rvalid);
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_STEP;
        if (drop) drop_cnt <= drop_cnt - CNT_W'(1);
        if (push) begin
          tail    <= tail + PTR_W'(1);
          resp_pc <= resp_pc + PC_STEP;
        end
        if (pop) head <= head + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue storage; cleared on reset so the head reads as an empty entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= INIT_ADDR;
      end
    end else if (push) begin
      q_instr[tail] <= bus.imem_rdata;
      q_pc[tail]    <= resp_pc;
    end
  end

  // The credit scheme must never let a response land in a full queue,
  // and the memory must never answer a request that was not made.
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    push |-> (count != CNT_W'(DEPTH)));
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    bus.imem_rvalid |-> (outstanding != '0));

`ifdef FETCH_PERF_EN
  // Saturating count of cycles where decode had nothing to take.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
    end else if (!bus.out_valid && (perf_stall_cycles != '1)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
